// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//
// Request/response bundle between the MEM stage (master) and the data-memory
// responder (slave).
//
//   req_addr_i     byte address of the access
//   req_rd_wr_i    0 = read, 1 = write
//   req_op_en_i    request valid; held stable by the master while stall_o=1
//   req_wr_data_i  write data, word-aligned lanes
//   req_wr_keep_i  per-bit write mask, 1 = bit written
//   rsp_rd_data_o  registered read word, held until the next completed read
//   rsp_valid_o    one-cycle completion pulse (reads and writes)
//   rsp_err_o      out-of-range flag, meaningful only with rsp_valid_o
//   stall_o        pipeline hold request
//
// The _i/_o suffixes are from the responder's point of view.
// ---------------------------------------------------------------------------
interface dmem_responder_if #(
  parameter int WD_SIZE = 32
) ();
  logic [WD_SIZE-1:0] req_addr_i;
  logic               req_rd_wr_i;
  logic               req_op_en_i;
  logic [WD_SIZE-1:0] req_wr_data_i;
  logic [WD_SIZE-1:0] req_wr_keep_i;
  logic [WD_SIZE-1:0] rsp_rd_data_o;
  logic               rsp_valid_o;
  logic               rsp_err_o;
  logic               stall_o;

  // Initiator side (pipeline MEM stage).
  modport master (
    output req_addr_i, req_rd_wr_i, req_op_en_i, req_wr_data_i, req_wr_keep_i,
    input  rsp_rd_data_o, rsp_valid_o, rsp_err_o, stall_o
  );

  // Memory side (this responder).
  modport slave (
    input  req_addr_i, req_rd_wr_i, req_op_en_i, req_wr_data_i, req_wr_keep_i,
    output rsp_rd_data_o, rsp_valid_o, rsp_err_o, stall_o
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the MEM-stage data-memory request bus. It turns
// the former zero-wait dmem into a multi-cycle memory: every request is
// accepted in IDLE, spends LATENCY cycles in WAIT, performs the array access
// on the last WAIT cycle and reports completion with a one-cycle pulse in
// DONE. The pipeline is held through stall_o for the whole time the request
// is outstanding.
//
// Storage is a byte-addressed little-endian array that is (re)loaded from
// init_data_i whenever reset_n is low. Accesses at or beyond MEM_SIZE_BYTES
// leave the array untouched and complete with rsp_err_o=1.
//
// Parameters
//   WD_SIZE         data/address width in bits (word = 4 bytes, so 32)
//   MEM_SIZE_BYTES  array size in bytes, multiple of 4, at least 8
//   LATENCY         wait cycles between accept and array access, 1..15
//
// Ports
//   clk            clock
//   reset_n        asynchronous active-low reset; aborts an in-flight request
//   bus            dmem_responder_if.slave request/response bundle
//   init_data_i    array image, byte n = bits [8n+7:8n]
//   stat_rd_cnt_o  saturating count of completed in-range reads
//   stat_wr_cnt_o  saturating count of completed in-range writes
//
// Optional feature
//   Define DMEM_RESPONDER_STATS_EN to build the two statistics counters.
//   Without it both stat outputs are tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int WD_SIZE        = 32,
  parameter int MEM_SIZE_BYTES = 128,
  parameter int LATENCY        = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  dmem_responder_if.slave             bus,
  input  logic [MEM_SIZE_BYTES*8-1:0] init_data_i,
  output logic [15:0]                 stat_rd_cnt_o,
  output logic [15:0]                 stat_wr_cnt_o
);

  localparam int AW = $clog2(MEM_SIZE_BYTES);   // in-array byte index width
  localparam int CW = 4;                        // wait counter width (LATENCY<=15)
  localparam logic [WD_SIZE-1:0] MEM_LIMIT = WD_SIZE'(MEM_SIZE_BYTES);
  localparam logic [CW-1:0]      CNT_INIT  = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t             state_q,   state_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic [WD_SIZE-1:0] addr_q,    addr_d;
  logic               rd_wr_q,   rd_wr_d;
  logic [WD_SIZE-1:0] wr_data_q, wr_data_d;
  logic [WD_SIZE-1:0] wr_keep_q, wr_keep_d;
  logic [WD_SIZE-1:0] rd_data_q, rd_data_d;
  logic               err_q,     err_d;
  logic [7:0]         mem_q [MEM_SIZE_BYTES];
  logic [7:0]         mem_d [MEM_SIZE_BYTES];

  logic               stall_c;
  logic               in_range;
  logic [AW-1:0]      base_addr;
  logic [WD_SIZE-1:0] old_word;
  logic [WD_SIZE-1:0] merged_word;

  // -------------------------------------------------------------------------
  // Word view of the captured address
  // -------------------------------------------------------------------------
  // Upper address bits only feed the range check; the array index uses the
  // low AW bits, so an out-of-range address never aliases into the array.
  assign in_range  = (addr_q < MEM_LIMIT);
  assign base_addr = {addr_q[AW-1:2], 2'b00};

  always_comb begin
    old_word = '0;
    for (int b = 0; b < 4; b++) begin
      old_word[8*b +: 8] = mem_q[base_addr + AW'(b)];
    end
  end

  assign merged_word = (old_word & ~wr_keep_q) | (wr_data_q & wr_keep_q);

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rd_wr_d   = rd_wr_q;
    wr_data_d = wr_data_q;
    wr_keep_d = wr_keep_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    mem_d     = mem_q;
    stall_c   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The stall must rise in the same cycle the request appears so the
        // pipeline does not advance past an unaccepted access.
        stall_c = bus.req_op_en_i;
        if (bus.req_op_en_i) begin
          addr_d    = bus.req_addr_i;
          rd_wr_d   = bus.req_rd_wr_i;
          wr_data_d = bus.req_wr_data_i;
          wr_keep_d = bus.req_wr_keep_i;
          cnt_d     = CNT_INIT;
          err_d     = 1'b0;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        stall_c = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          err_d   = ~in_range;
          state_d = S_DONE;
          if (in_range) begin
            if (rd_wr_q) begin
              for (int b = 0; b < 4; b++) begin
                mem_d[base_addr + AW'(b)] = merged_word[8*b +: 8];
              end
            end else begin
              rd_data_d = old_word;
            end
          end else if (!rd_wr_q) begin
            // Out-of-range reads return zero; writes keep the last read word.
            rd_data_d = '0;
          end
        end
      end

      S_DONE: begin
        // The master is releasing the completing request this cycle, so its
        // op_en is deliberately not looked at here.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_wr_q   <= 1'b0;
      wr_data_q <= '0;
      wr_keep_q <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
      for (int n = 0; n < MEM_SIZE_BYTES; n++) begin
        mem_q[n] <= init_data_i[8*n +: 8];
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rd_wr_q   <= rd_wr_d;
      wr_data_q <= wr_data_d;
      wr_keep_q <= wr_keep_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      mem_q     <= mem_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Gating with reset_n makes the stall drop as soon as reset is asserted,
  // even though the IDLE term is combinational from req_op_en_i.
  assign bus.stall_o       = reset_n & stall_c;
  assign bus.rsp_valid_o   = (state_q == S_DONE);
  assign bus.rsp_err_o     = (state_q == S_DONE) & err_q;
  assign bus.rsp_rd_data_o = rd_data_q;

  // -------------------------------------------------------------------------
  // Optional statistics
  // -------------------------------------------------------------------------
`ifdef DMEM_RESPONDER_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == S_DONE && !err_q) begin
      if (rd_wr_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign stat_rd_cnt_o = rd_cnt_q;
  assign stat_wr_cnt_o = wr_cnt_q;
`else
  assign stat_rd_cnt_o = 16'd0;
  assign stat_wr_cnt_o = 16'd0;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the data-memory request interface driven by the MEM stage (addr / rd_wr / op_en / wr_data / wr_keep / rd_data).
- Adds configurable wait states and a stall handshake so the pipeline sees a multi-cycle memory. It replaces the zero-wait dmem and is the stepping stone to a real cache or bus.
- Holds a byte-addressed little-endian array that is loaded from init_data_i at reset.
- Flags out-of-range accesses with a one-cycle error pulse.

Parameters:
- WD_SIZE, 32, data/address word width in bits.
- MEM_SIZE_BYTES, 128, array size in bytes; multiple of 4.
- LATENCY, 2, wait cycles between request accept and array access; legal range 1..15.

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset; asynchronous, active-low.
- req_addr_i  input  WD_SIZE  byte address; the word is selected by addr[..:2] and addr[1:0] is ignored.
- req_rd_wr_i  input  1  0 = read, 1 = write.
- req_op_en_i  input  1  request valid; the initiator holds all req_* stable while stall_o=1.
- req_wr_data_i  input  WD_SIZE  write data, word-aligned lanes.
- req_wr_keep_i  input  WD_SIZE  per-bit write mask; 1 = bit written.
- init_data_i  input  MEM_SIZE_BYTES*8  array image; byte n = bits [8n+7:8n].
- rsp_rd_data_o  output  WD_SIZE  read word; registered.
- rsp_valid_o  output  1  one-cycle completion pulse, for reads and writes.
- rsp_err_o  output  1  out-of-range flag; qualified by rsp_valid_o.
- stall_o  output  1  pipeline hold request.
- stat_rd_cnt_o  output  16  completed reads (optional feature).
- stat_wr_cnt_o  output  16  completed writes (optional feature).

Behaviour:
- Reset (async, while reset_n=0):
  - state=IDLE; all outputs 0; counters 0.
  - array[n] = init_data_i byte n.
  - Reset asserted mid-request aborts it: no write occurs, no rsp_valid_o. stall_o drops asynchronously.
- State machine IDLE -> WAIT -> DONE -> IDLE:
  - IDLE:
    - stall_o = req_op_en_i (combinational).
    - On req_op_en_i=1, capture addr, rd_wr, wr_data, wr_keep; cnt = LATENCY-1; go to WAIT.
  - WAIT:
    - stall_o=1.
    - If cnt!=0, decrement cnt.
    - If cnt==0, perform the access (below) and go to DONE.
  - DONE:
    - stall_o=0; rsp_valid_o=1 for exactly this cycle; rsp_err_o valid.
    - req_op_en_i is ignored in DONE; it is the completing request being released. Next state is IDLE.
- Timing: request first seen in IDLE at cycle T.
  - stall_o=1 for cycles T..T+LATENCY.
  - rsp_valid_o=1 at T+LATENCY+1.
  - Back-to-back throughput is one request per LATENCY+2 cycles.
- Access rules at the WAIT cycle with cnt==0:
  - In range means addr < MEM_SIZE_BYTES.
  - Read, in range: rsp_rd_data_o = {array[a+3], array[a+2], array[a+1], array[a]}, where a = addr & ~3.
  - Write, in range: each bit i of the word becomes (keep[i] ? wr_data[i] : old[i]). rsp_rd_data_o is unchanged.
  - Out of range: no array change; rsp_err_o=1 in DONE. A read also forces rsp_rd_data_o=0.
- rsp_rd_data_o holds its value until the next completed read.
- rsp_err_o=0 whenever rsp_valid_o=0.
- req_* changes while stall_o=1 are a protocol violation. The captured copy is used; no checking is done.
- Address width: bits above log2(MEM_SIZE_BYTES) take part only in the range check; there is no wrap-around.

Optional Feature:
- DMEM_RESPONDER_STATS_EN defined:
  - stat_rd_cnt_o increments on each in-range read DONE; stat_wr_cnt_o increments on each in-range write DONE.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: both ports tied to 0 and no counter flops are present.

Test Plan:
- Reset with init byte n = n, LATENCY=2; read addr 0x04 -> stall_o high 3 cycles, rsp_valid_o at T+3, rsp_rd_data_o=0x07060504, rsp_err_o=0.
- Write addr 0x08, data 0xAABBCCDD, keep 0x0000FFFF; then read 0x08 -> 0x0B0ACCDD.
- Read addr 0x81 with MEM_SIZE_BYTES=128 -> rsp_err_o=1, rsp_rd_data_o=0; a follow-up read of 0x00 returns 0x03020100 (array unchanged).
- Back-to-back reads 0x00 then 0x7C, with op_en held continuously -> rsp_valid_o pulses exactly 4 cycles apart, with data 0x03020100 then 0x7F7E7D7C.
- reset_n pulsed low during WAIT of a write to 0x10, keep all 1s -> no rsp_valid_o; a later read of 0x10 returns the init value 0x13121110.
- With DMEM_RESPONDER_STATS_EN: 3 in-range reads, 2 in-range writes, 1 error -> stat_rd_cnt_o=3, stat_wr_cnt_o=2; without the macro both read 0.
